// File: rtl/controle_pkg.sv
// controle_pkg: shared definitions for the multicycle RISC-V control path.
// Contents:
//   state_t       4-bit sequencer state encodings (IF=0 .. PC=8, HALT=9)
//   OPC_*         7-bit major opcodes of the supported instruction subset
//   instr_class_t instruction class decided in ID
package controle_pkg;

  typedef enum logic [3:0] {
    ST_IF   = 4'd0,
    ST_ID   = 4'd1,
    ST_EX   = 4'd2,
    ST_MEM  = 4'd3,
    ST_WB   = 4'd4,
    ST_PC   = 4'd8,
    ST_HALT = 4'd9
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_OP,
    CLS_OPIMM,
    CLS_BRANCH,
    CLS_ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/instr_class.sv
// instr_class: purely combinational opcode -> instruction class decoder.
// Ports:
//   opcode  in   instr[6:0]
//   cls     out  decoded class; anything outside the subset is CLS_ILLEGAL
module instr_class
  import controle_pkg::*;
(
  input  logic [6:0]   opcode,
  output instr_class_t cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_OP:     cls = CLS_OP;
      OPC_OPIMM:  cls = CLS_OPIMM;
      OPC_BRANCH: cls = CLS_BRANCH;
      default:    cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: Moore control sequencer for the multicycle datapath.
// Walks IF -> ID -> EX -> [MEM] -> [WB] -> PC per instruction, skipping
// phases by class, with programmable EX/MEM/WB latencies.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             freezes state and wait counter (ignored in HALT)
//   instr             instruction word, sampled while in ID
//   mem_ready         data memory completion, see handshake note below
//   estado            current state encoding (doubles as FSM debug view)
//   if_en..pc_en      phase enables, decoded straight from estado
//   halted, illegal   HALT indication, sticky unknown-opcode flag
//   cycle_cnt         non-halted cycles since reset, saturating
//   instret           retired instructions, saturating
// Handshake: once the MEM wait counter has expired, MEM is left on the first
// rising edge where mem_ready=1 (and stall=0); mem_ready is don't-care while
// the counter is still running and outside MEM.
module multicycle_sequencer
  import controle_pkg::*;
#(
  parameter int EX_LAT  = 3,
  parameter int MEM_LAT = 1,
  parameter int WB_LAT  = 3,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  output logic [3:0]       estado,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  // Counter only has to hold the largest LAT-1 value.
  localparam int MAX_LAT = (EX_LAT > MEM_LAT) ? ((EX_LAT > WB_LAT) ? EX_LAT : WB_LAT)
                                              : ((MEM_LAT > WB_LAT) ? MEM_LAT : WB_LAT);
  localparam int WAIT_W  = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [WAIT_W-1:0] EX_LOAD  = WAIT_W'(EX_LAT - 1);
  localparam logic [WAIT_W-1:0] MEM_LOAD = WAIT_W'(MEM_LAT - 1);
  localparam logic [WAIT_W-1:0] WB_LOAD  = WAIT_W'(WB_LAT - 1);

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  instr_class_t      cls_q, cls_dec;
  logic              set_illegal;
  logic              retire;
  logic              hold;

  instr_class u_instr_class (
    .opcode (instr[6:0]),
    .cls    (cls_dec)
  );

  // HALT is absorbing, so stall has nothing to freeze there.
  assign hold = stall && (state != ST_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IF;
      wait_cnt  <= '0;
      cls_q     <= CLS_LOAD;
      illegal   <= 1'b0;
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      // Cycle counter keeps running through stalls, stops only in HALT.
      if ((state != ST_HALT) && (cycle_cnt != '1)) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if (!hold) begin
        state    <= state_next;
        wait_cnt <= wait_next;
        // Class is captured once in ID; instr is free to move afterwards.
        if (state == ST_ID) begin
          cls_q <= cls_dec;
        end
        if (set_illegal) begin
          illegal <= 1'b1;
        end
        if (retire && (instret != '1)) begin
          instret <= instret + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_next  = state;
    wait_next   = wait_cnt;
    set_illegal = 1'b0;
    retire      = 1'b0;
    case (state)
      ST_IF: state_next = ST_ID;
      ST_ID: begin
        if (instr == 32'd0) begin
          state_next = ST_HALT;
        end else if (cls_dec == CLS_ILLEGAL) begin
          state_next  = ST_HALT;
          set_illegal = 1'b1;
        end else begin
          state_next = ST_EX;
          wait_next  = EX_LOAD;
        end
      end
      ST_EX: begin
        if (wait_cnt == '0) begin
          case (cls_q)
            CLS_LOAD, CLS_STORE: begin
              state_next = ST_MEM;
              wait_next  = MEM_LOAD;
            end
            CLS_BRANCH: state_next = ST_PC;
            default: begin
              state_next = ST_WB;
              wait_next  = WB_LOAD;
            end
          endcase
        end else begin
          wait_next = wait_cnt - WAIT_W'(1);
        end
      end
      ST_MEM: begin
        if (wait_cnt != '0) begin
          wait_next = wait_cnt - WAIT_W'(1);
        end else if (mem_ready) begin
          if (cls_q == CLS_LOAD) begin
            state_next = ST_WB;
            wait_next  = WB_LOAD;
          end else begin
            state_next = ST_PC;
          end
        end
      end
      ST_WB: begin
        if (wait_cnt == '0) begin
          state_next = ST_PC;
        end else begin
          wait_next = wait_cnt - WAIT_W'(1);
        end
      end
      ST_PC: begin
        state_next = ST_IF;
        retire     = 1'b1;
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IF;
    endcase
  end

  assign estado = state;
  assign if_en  = (state == ST_IF);
  assign id_en  = (state == ST_ID);
  assign ex_en  = (state == ST_EX);
  assign mem_en = (state == ST_MEM);
  assign wb_en  = (state == ST_WB);
  assign pc_en  = (state == ST_PC);
  assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed bench for multicycle_sequencer.
// dut uses default latencies; dut_b uses EX_LAT=1 and CNT_W=4 and runs
// branches continuously so its counters saturate.
module tb_multicycle_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, mem_ready;
  logic [31:0] instr;
  logic [3:0]  estado;
  logic        if_en, id_en, ex_en, mem_en, wb_en, pc_en, halted, illegal;
  logic [31:0] cycle_cnt, instret;

  logic        rst_b;
  logic [31:0] instr_b;
  logic [3:0]  estado_b;
  logic        if_en_b, id_en_b, ex_en_b, mem_en_b, wb_en_b, pc_en_b, halted_b, illegal_b;
  logic [3:0]  cycle_cnt_b, instret_b;

  multicycle_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .instr(instr), .mem_ready(mem_ready),
    .estado(estado), .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en),
    .wb_en(wb_en), .pc_en(pc_en), .halted(halted), .illegal(illegal),
    .cycle_cnt(cycle_cnt), .instret(instret)
  );

  multicycle_sequencer #(.EX_LAT(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .stall(1'b0), .instr(instr_b), .mem_ready(1'b1),
    .estado(estado_b), .if_en(if_en_b), .id_en(id_en_b), .ex_en(ex_en_b), .mem_en(mem_en_b),
    .wb_en(wb_en_b), .pc_en(pc_en_b), .halted(halted_b), .illegal(illegal_b),
    .cycle_cnt(cycle_cnt_b), .instret(instret_b)
  );

  localparam logic [31:0] I_OP     = 32'h002081B3;
  localparam logic [31:0] I_OPIMM  = 32'h00500093;
  localparam logic [31:0] I_LOAD   = 32'h0000A183;
  localparam logic [31:0] I_STORE  = 32'h0020A023;
  localparam logic [31:0] I_BRANCH = 32'h00208463;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        halt;
    logic        ill;
    logic [7:0]  ex;
    logic [7:0]  mem;
    logic [7:0]  wb;
    logic [7:0]  tot;
    logic [7:0]  dcc;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_qb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_ret    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic h, input logic il, input int ex, input int mem,
                              input int wb, input int tot, input int dcc, input int ret);
    exp_t e;
    e.halt = h;        e.ill = il;
    e.ex   = 8'(ex);   e.mem = 8'(mem);  e.wb = 8'(wb);
    e.tot  = 8'(tot);  e.dcc = 8'(dcc);  e.ret = 32'(ret);
    return e;
  endfunction

  // ---------------- monitor (dut) ----------------
  int          a_ex, a_mem, a_wb, a_tot;
  logic [31:0] a_cc0;
  bit          a_act = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (if_en === 1'b1) begin
      a_act = 1'b1; a_tot = 1; a_ex = 0; a_mem = 0; a_wb = 0; a_cc0 = cycle_cnt;
    end else if (a_act) begin
      a_tot++;
      if (ex_en)  a_ex++;
      if (mem_en) a_mem++;
      if (wb_en)  a_wb++;
      if (pc_en || halted) begin
        a_act = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("halted",   32'(halted),  32'(e.halt));
          check("illegal",  32'(illegal), 32'(e.ill));
          check("ex_cycles",  32'(a_ex),  32'(e.ex));
          check("mem_cycles", 32'(a_mem), 32'(e.mem));
          check("wb_cycles",  32'(a_wb),  32'(e.wb));
          check("total_cycles", 32'(a_tot), 32'(e.tot));
          check("cycle_cnt_delta", cycle_cnt - a_cc0, 32'(e.dcc));
          check("instret_at_end", instret, e.ret);
        end
      end
    end
  end

  // ---------------- monitor (dut_b) ----------------
  int b_ex, b_mem, b_wb, b_tot;
  bit b_act = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (if_en_b === 1'b1) begin
      b_act = 1'b1; b_tot = 1; b_ex = 0; b_mem = 0; b_wb = 0;
    end else if (b_act) begin
      b_tot++;
      if (ex_en_b)  b_ex++;
      if (mem_en_b) b_mem++;
      if (wb_en_b)  b_wb++;
      if (pc_en_b) begin
        b_act = 1'b0;
        if (exp_qb.size() > 0) begin
          e = exp_qb.pop_front();
          check("b_ex_cycles",  32'(b_ex),  32'(e.ex));
          check("b_mem_cycles", 32'(b_mem), 32'(e.mem));
          check("b_wb_cycles",  32'(b_wb),  32'(e.wb));
          check("b_total_cycles", 32'(b_tot), 32'(e.tot));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_ret = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_estado"}, 32'(estado), 32'd0);
    check({tag, "_if_en"}, 32'(if_en), 32'd1);
    check({tag, "_other_en"}, 32'({id_en, ex_en, mem_en, wb_en, pc_en}), 32'd0);
    check({tag, "_flags"}, 32'({halted, illegal}), 32'd0);
    check({tag, "_cycle_cnt"}, cycle_cnt, 32'd0);
    check({tag, "_instret"}, instret, 32'd0);
  endtask

  task automatic wait_if();
    int budget = 60;
    while (if_en !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("wait_if_timeout", 32'd1, 32'd0);
  endtask

  // Issues one instruction at an IF cycle and follows it to PC or HALT.
  task automatic run_instr(input logic [31:0] iw, input exp_t e, input int mem_low, input bit stall_wb);
    int budget = 60;
    int mseen  = 0;
    int wseen  = 0;
    wait_if();
    instr     = iw;
    mem_ready = (mem_low == 0);
    exp_q.push_back(e);
    do begin
      @(negedge clk);
      budget--;
      if (mem_en) begin
        mseen++;
        if (mseen == mem_low + 1) mem_ready = 1'b1;
      end
      if (stall_wb && wb_en) begin
        wseen++;
        if (wseen == 2) stall = 1'b1;
        if (wseen == 4) stall = 1'b0;
      end
    end while (!(pc_en || halted) && budget > 0);
    if (budget == 0) begin
      check("instr_timeout", 32'd1, 32'd0);
      void'(exp_q.pop_back());
    end
    if (pc_en) begin
      n_ret++;
      @(negedge clk);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    instr   = 32'd0;
    instr_b = I_BRANCH;
    rst_b   = 1'b1;
    exp_qb.push_back(mk(0, 0, 1, 0, 0, 4, 3, 0));
    exp_qb.push_back(mk(0, 0, 1, 0, 0, 4, 3, 1));
    do_reset();
    rst_b = 1'b0;
    check_reset("rst0");

    run_instr(I_OP,     mk(0, 0, 3, 0, 3,  9,  8, 0), 0, 0);
    run_instr(I_OPIMM,  mk(0, 0, 3, 0, 3,  9,  8, 1), 0, 0);
    run_instr(I_LOAD,   mk(0, 0, 3, 5, 3, 14, 13, 2), 4, 0);
    run_instr(I_LOAD,   mk(0, 0, 3, 1, 3, 10,  9, 3), 0, 0);
    run_instr(I_STORE,  mk(0, 0, 3, 1, 0,  7,  6, 4), 0, 0);
    run_instr(I_BRANCH, mk(0, 0, 3, 0, 0,  6,  5, 5), 0, 0);
    run_instr(I_OP,     mk(0, 0, 3, 0, 5, 11, 10, 6), 0, 1);
    check("instret_after_seq", instret, 32'd7);
    check("cycle_cnt_after_seq", cycle_cnt, 32'd66);

    // Zero instruction halts without flagging illegal; counters freeze.
    do_reset();
    check_reset("rst1");
    run_instr(32'd0, mk(1, 0, 0, 0, 0, 3, 2, 0), 0, 0);
    repeat (5) @(negedge clk);
    check("halt0_estado", 32'(estado), 32'd9);
    check("halt0_halted", 32'(halted), 32'd1);
    check("halt0_illegal", 32'(illegal), 32'd0);
    check("halt0_cycle_frozen", cycle_cnt, 32'd2);
    check("halt0_instret", instret, 32'd0);

    // Unknown opcode halts with illegal set.
    do_reset();
    check_reset("rst2");
    run_instr(32'h0000007F, mk(1, 1, 0, 0, 0, 3, 2, 0), 0, 0);
    repeat (3) @(negedge clk);
    check("halt1_illegal_sticky", 32'(illegal), 32'd1);
    check("halt1_cycle_frozen", cycle_cnt, 32'd2);
    do_reset();
    check_reset("rst3");

    // Reset in the middle of EX of a LOAD, then a clean restart.
    wait_if();
    instr = I_LOAD;
    for (int k = 0; k < 20 && !ex_en; k++) @(negedge clk);
    check("abort_reached_ex", 32'(ex_en), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_ret = 0;
    check_reset("rst_mid_ex");
    run_instr(I_OP, mk(0, 0, 3, 0, 3, 9, 8, 0), 0, 0);
    check("restart_instret", instret, 32'd1);
    check("restart_cycle_cnt", cycle_cnt, 32'd9);

    // dut_b has run well over 60 cycles of 4-cycle branches: both saturate.
    check("b_cycle_cnt_sat", 32'(cycle_cnt_b), 32'd15);
    check("b_instret_sat", 32'(instret_b), 32'd15);
    check("b_mem_wb_idle", 32'({mem_en_b, wb_en_b, halted_b, illegal_b}), 32'd0);

    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    check("sb_b_queue_empty", 32'(exp_qb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
